// File: rtl/rob_pkg.sv
// Shared encodings and widths for the wide reorder buffer.
// Defining ROB_DUAL_COMMIT_EN selects two commit lanes instead of one.
package rob_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

`ifdef ROB_DUAL_COMMIT_EN
  localparam int NC = 2;
`else
  localparam int NC = 1;
`endif

  typedef enum logic [1:0] {
    TYPE_ALU = 2'd0,
    TYPE_BR  = 2'd1,
    TYPE_ST  = 2'd2,
    TYPE_LD  = 2'd3
  } rob_type_e;

  function automatic logic writesReg(rob_type_e t);
    return (t == TYPE_ALU) || (t == TYPE_LD);
  endfunction

endpackage

// File: rtl/rob_ptr_inc.sv
// Advances a ROB pointer by 1 or 2, wrapping from DEPTH-1 back to 1 so that
// slot 0 (the "no dependency" alias) is never produced.
module rob_ptr_inc #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] ptr_i,
  input  logic [1:0]    step_i,
  output logic [AW-1:0] next_o
);

  logic [AW:0] sum;
  logic [AW:0] wrapped;

  always_comb begin
    sum     = {1'b0, ptr_i} + {{(AW-1){1'b0}}, step_i};
    wrapped = sum;
    if (sum >= (AW+1)'(DEPTH)) begin
      wrapped = sum - (AW+1)'(DEPTH - 1);
    end
    next_o = wrapped[AW-1:0];
  end

endmodule

// File: rtl/rob_wide.sv
// Reorder buffer with multi-port writeback, operand bypass and in-order commit.
// ROB_DUAL_COMMIT_EN adds a second commit lane retiring head+1 alongside head.
module rob_wide
  import rob_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int NUM_WB = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  output logic                   full,
  input  logic                   issue_valid,
  input  logic [XLEN-1:0]        issue_pc,
  input  logic [REGW-1:0]        issue_rd,
  input  logic [1:0]             issue_type,
  input  logic                   issue_pred_taken,
  output logic [AW-1:0]          issue_alias,
  input  logic [AW-1:0]          qj,
  input  logic [AW-1:0]          qk,
  output logic                   vj_ok,
  output logic                   vk_ok,
  output logic [XLEN-1:0]        vj,
  output logic [XLEN-1:0]        vk,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_alias,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  input  logic [NUM_WB-1:0]      wb_taken,
  input  logic [NUM_WB*XLEN-1:0] wb_target,
  output logic [NC-1:0]          cm_valid,
  output logic [NC*REGW-1:0]     cm_rd,
  output logic [NC*AW-1:0]       cm_alias,
  output logic [NC*XLEN-1:0]     cm_data,
  output logic                   st_commit,
  output logic [AW-1:0]          st_alias,
  output logic                   bp_update,
  output logic [XLEN-1:0]        bp_pc,
  output logic                   bp_taken,
  output logic                   rollback,
  output logic [XLEN-1:0]        rollback_pc
);

  localparam logic [AW-1:0] FIRST     = AW'(1);
  localparam logic [AW:0]   MAX_COUNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   FULL_AT   = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  logic [AW-1:0]   head_q, tail_q, headNext, tailNext;
  logic [AW:0]     count_q, count_d;
  logic [DEPTH-1:0] entryValid_q, entryReady_q, entryTaken_q, entryPred_q;
  logic [XLEN-1:0] entryPc_q [DEPTH];
  logic [XLEN-1:0] entryData_q [DEPTH];
  logic [XLEN-1:0] entryTarget_q [DEPTH];
  logic [REGW-1:0] entryRd_q [DEPTH];
  rob_type_e       entryType_q [DEPTH];

  logic [NC-1:0]      cm_valid_q;
  logic [NC*REGW-1:0] cm_rd_q;
  logic [NC*AW-1:0]   cm_alias_q;
  logic [NC*XLEN-1:0] cm_data_q;
  logic               st_commit_q, bp_update_q, bp_taken_q, rollback_q;
  logic [AW-1:0]      st_alias_q;
  logic [XLEN-1:0]    bp_pc_q, rollback_pc_q;

  logic      headReady, retire2, mispredict, issueFire;
  logic [1:0] headStep;
  rob_type_e headType;

  rob_ptr_inc #(.DEPTH(DEPTH)) incTail (.ptr_i(tail_q), .step_i(2'd1), .next_o(tailNext));
  rob_ptr_inc #(.DEPTH(DEPTH)) incHead (.ptr_i(head_q), .step_i(headStep), .next_o(headNext));

`ifdef ROB_DUAL_COMMIT_EN
  logic [AW-1:0] headNext1;
  rob_ptr_inc #(.DEPTH(DEPTH)) incHead1 (.ptr_i(head_q), .step_i(2'd1), .next_o(headNext1));
`endif

  always_comb begin
    headType   = entryType_q[head_q];
    headReady  = entryValid_q[head_q] & entryReady_q[head_q];
    mispredict = headReady && (headType == TYPE_BR) &&
                 (entryTaken_q[head_q] != entryPred_q[head_q]);
`ifdef ROB_DUAL_COMMIT_EN
    retire2 = headReady && writesReg(headType) && (headNext1 != tail_q) &&
              entryValid_q[headNext1] && entryReady_q[headNext1] &&
              writesReg(entryType_q[headNext1]);
`else
    retire2 = 1'b0;
`endif
    headStep  = retire2 ? 2'd2 : 2'd1;
    issueFire = issue_valid && (count_q != MAX_COUNT) && !mispredict;
    count_d   = count_q;
    if (issueFire) count_d = count_d + CNT_ONE;
    if (headReady) count_d = count_d - CNT_ONE;
    if (retire2)   count_d = count_d - CNT_ONE;
  end

  // Operand query: alias 0 never resolves; live writebacks beat stored state.
  always_comb begin
    vj_ok = 1'b0;
    vj    = '0;
    vk_ok = 1'b0;
    vk    = '0;
    if (qj != '0) begin
      vj_ok = entryReady_q[qj];
      vj    = entryData_q[qj];
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && (wb_alias[p*AW +: AW] == qj)) begin
          vj_ok = 1'b1;
          vj    = wb_data[p*XLEN +: XLEN];
        end
      end
    end
    if (qk != '0) begin
      vk_ok = entryReady_q[qk];
      vk    = entryData_q[qk];
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && (wb_alias[p*AW +: AW] == qk)) begin
          vk_ok = 1'b1;
          vk    = wb_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= FIRST;
      tail_q        <= FIRST;
      count_q       <= '0;
      entryValid_q  <= '0;
      entryReady_q  <= '0;
      cm_valid_q    <= '0;
      cm_rd_q       <= '0;
      cm_alias_q    <= '0;
      cm_data_q     <= '0;
      st_commit_q   <= 1'b0;
      st_alias_q    <= '0;
      bp_update_q   <= 1'b0;
      bp_pc_q       <= '0;
      bp_taken_q    <= 1'b0;
      rollback_q    <= 1'b0;
      rollback_pc_q <= '0;
    end else if (!rdy) begin
      cm_valid_q  <= '0;
      st_commit_q <= 1'b0;
      bp_update_q <= 1'b0;
      rollback_q  <= 1'b0;
    end else begin
      cm_valid_q  <= '0;
      st_commit_q <= 1'b0;
      bp_update_q <= 1'b0;
      rollback_q  <= 1'b0;
      if (headReady) begin
        case (headType)
          TYPE_ST: begin
            st_commit_q <= 1'b1;
            st_alias_q  <= head_q;
          end
          TYPE_BR: begin
            bp_update_q <= 1'b1;
            bp_pc_q     <= entryPc_q[head_q];
            bp_taken_q  <= entryTaken_q[head_q];
            if (entryRd_q[head_q] != '0) begin
              cm_valid_q[0]          <= 1'b1;
              cm_rd_q[REGW-1:0]      <= entryRd_q[head_q];
              cm_alias_q[AW-1:0]     <= head_q;
              cm_data_q[XLEN-1:0]    <= entryData_q[head_q];
            end
          end
          default: begin
            cm_valid_q[0]       <= 1'b1;
            cm_rd_q[REGW-1:0]   <= entryRd_q[head_q];
            cm_alias_q[AW-1:0]  <= head_q;
            cm_data_q[XLEN-1:0] <= entryData_q[head_q];
          end
        endcase
      end
      // A mispredicted branch flushes everything younger, including this edge's traffic.
      if (mispredict) begin
        rollback_q    <= 1'b1;
        rollback_pc_q <= entryTaken_q[head_q] ? entryTarget_q[head_q]
                                              : entryPc_q[head_q] + 32'd4;
        entryValid_q  <= '0;
        entryReady_q  <= '0;
        head_q        <= FIRST;
        tail_q        <= FIRST;
        count_q       <= '0;
      end else begin
        for (int p = 0; p < NUM_WB; p++) begin
          if (wb_valid[p] && (wb_alias[p*AW +: AW] != '0) &&
              entryValid_q[wb_alias[p*AW +: AW]]) begin
            entryReady_q[wb_alias[p*AW +: AW]] <= 1'b1;
          end
        end
        if (headReady) begin
          entryValid_q[head_q] <= 1'b0;
          entryReady_q[head_q] <= 1'b0;
          head_q               <= headNext;
        end
`ifdef ROB_DUAL_COMMIT_EN
        if (retire2) begin
          entryValid_q[headNext1]    <= 1'b0;
          entryReady_q[headNext1]    <= 1'b0;
          cm_valid_q[1]              <= 1'b1;
          cm_rd_q[REGW +: REGW]      <= entryRd_q[headNext1];
          cm_alias_q[AW +: AW]       <= headNext1;
          cm_data_q[XLEN +: XLEN]    <= entryData_q[headNext1];
        end
`endif
        if (issueFire) begin
          entryValid_q[tail_q] <= 1'b1;
          entryReady_q[tail_q] <= 1'b0;
          tail_q               <= tailNext;
        end
        count_q <= count_d;
      end
    end
  end

  // Entry payload needs no reset: it is only observed through valid/ready.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !mispredict) begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && (wb_alias[p*AW +: AW] != '0) &&
            entryValid_q[wb_alias[p*AW +: AW]]) begin
          entryData_q[wb_alias[p*AW +: AW]]   <= wb_data[p*XLEN +: XLEN];
          entryTaken_q[wb_alias[p*AW +: AW]]  <= wb_taken[p];
          entryTarget_q[wb_alias[p*AW +: AW]] <= wb_target[p*XLEN +: XLEN];
        end
      end
      if (issueFire) begin
        entryPc_q[tail_q]   <= issue_pc;
        entryRd_q[tail_q]   <= issue_rd;
        entryType_q[tail_q] <= rob_type_e'(issue_type);
        entryPred_q[tail_q] <= issue_pred_taken;
      end
    end
  end

  assign full        = (count_q >= FULL_AT);
  assign issue_alias = tail_q;
  assign cm_valid    = cm_valid_q & {NC{rdy}};
  assign cm_rd       = cm_rd_q;
  assign cm_alias    = cm_alias_q;
  assign cm_data     = cm_data_q;
  assign st_commit   = st_commit_q & rdy;
  assign st_alias    = st_alias_q;
  assign bp_update   = bp_update_q & rdy;
  assign bp_pc       = bp_pc_q;
  assign bp_taken    = bp_taken_q;
  assign rollback    = rollback_q & rdy;
  assign rollback_pc = rollback_pc_q;

endmodule

// File: tb/tb_rob_wide.sv
// Directed bench for rob_wide at DEPTH=8 with two writeback ports.
// Exercises the single-lane build, or the dual-commit lanes when ROB_DUAL_COMMIT_EN is defined.
module tb_rob_wide;
  import rob_pkg::*;

  localparam int DEPTH  = 8;
  localparam int NUM_WB = 2;
  localparam int AW     = $clog2(DEPTH);

  logic                   clk, rst, rdy, full;
  logic                   issue_valid, issue_pred_taken;
  logic [31:0]            issue_pc;
  logic [4:0]             issue_rd;
  logic [1:0]             issue_type;
  logic [AW-1:0]          issue_alias, qj, qk, st_alias;
  logic                   vj_ok, vk_ok, st_commit, bp_update, bp_taken, rollback;
  logic [31:0]            vj, vk, bp_pc, rollback_pc;
  logic [NUM_WB-1:0]      wb_valid, wb_taken;
  logic [NUM_WB*AW-1:0]   wb_alias;
  logic [NUM_WB*32-1:0]   wb_data, wb_target;
  logic [NC-1:0]          cm_valid;
  logic [NC*5-1:0]        cm_rd;
  logic [NC*AW-1:0]       cm_alias;
  logic [NC*32-1:0]       cm_data;

  int vectors     = 0;
  int miscompares = 0;

  rob_wide #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .full(full),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_rd(issue_rd),
    .issue_type(issue_type), .issue_pred_taken(issue_pred_taken),
    .issue_alias(issue_alias), .qj(qj), .qk(qk),
    .vj_ok(vj_ok), .vk_ok(vk_ok), .vj(vj), .vk(vk),
    .wb_valid(wb_valid), .wb_alias(wb_alias), .wb_data(wb_data),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_alias(cm_alias), .cm_data(cm_data),
    .st_commit(st_commit), .st_alias(st_alias),
    .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one issue slot across a clock edge, then clears issue and writebacks.
  task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [4:0] rd,
                               input rob_type_e ty, input logic pred);
    issue_valid      = iv;
    issue_pc         = pc;
    issue_rd         = rd;
    issue_type       = ty;
    issue_pred_taken = pred;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    wb_valid    = '0;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 5'd0, TYPE_ALU, 1'b0);
  endtask

  task automatic setWb(input int port, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic tk, input logic [31:0] tgt);
    wb_valid[port]             = 1'b1;
    wb_alias[port*AW +: AW]    = a;
    wb_data[port*32 +: 32]     = d;
    wb_taken[port]             = tk;
    wb_target[port*32 +: 32]   = tgt;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    issue_valid = 1'b0; issue_pc = '0; issue_rd = '0; issue_type = '0; issue_pred_taken = 1'b0;
    qj = '0; qk = '0;
    wb_valid = '0; wb_alias = '0; wb_data = '0; wb_taken = '0; wb_target = '0;
    idle();
    idle();
    rst = 1'b0;
    checkOutput("reset_full", full, 0);
    checkOutput("reset_issue_alias", issue_alias, 1);
    checkOutput("reset_cm_valid", cm_valid, 0);
    checkOutput("reset_rollback", rollback, 0);
    checkOutput("reset_st_commit", st_commit, 0);
    checkOutput("reset_bp_update", bp_update, 0);
    checkOutput("reset_vj_ok_alias0", vj_ok, 0);

`ifndef ROB_DUAL_COMMIT_EN
    // Fill: six ALU ops take aliases 1..6, full rises with the sixth.
    for (int i = 1; i <= 6; i++) begin
      checkOutput($sformatf("alloc_alias_%0d", i), issue_alias, 32'(i));
      applyStimulus(1'b1, 32'h10 * i, 5'(i), TYPE_ALU, 1'b0);
      if (i == 5) checkOutput("full_after_5", full, 0);
    end
    checkOutput("full_after_6", full, 1);
    checkOutput("alloc_alias_7", issue_alias, 7);
    applyStimulus(1'b1, 32'h70, 5'd7, TYPE_ALU, 1'b0);
    checkOutput("tail_wraps_to_1", issue_alias, 1);
    applyStimulus(1'b1, 32'hEE, 5'd8, TYPE_ALU, 1'b0);
    checkOutput("issue_ignored_at_7", issue_alias, 1);
    checkOutput("full_at_7", full, 1);

    // Bypass with colliding ports: port 1 wins.
    qj = 3; qk = 4;
    setWb(0, 3'd3, 32'h1111, 1'b0, 32'h0);
    setWb(1, 3'd3, 32'hDEAD, 1'b0, 32'h0);
    #1;
    checkOutput("bypass_vj_ok", vj_ok, 1);
    checkOutput("bypass_vj", vj, 32'hDEAD);
    checkOutput("vk_not_ready", vk_ok, 0);
    idle();
    checkOutput("stored_vj_ok", vj_ok, 1);
    checkOutput("stored_vj_port1_wins", vj, 32'hDEAD);

    setWb(0, 3'd1, 32'hA1, 1'b0, 32'h0);
    idle();
    checkOutput("no_commit_before_ready", cm_valid, 0);
    idle();
    checkOutput("commit1_valid", cm_valid, 1);
    checkOutput("commit1_alias", cm_alias, 1);
    checkOutput("commit1_rd", cm_rd, 1);
    checkOutput("commit1_data", cm_data, 32'hA1);

    // Wrap: the freed slot 1 is reallocated, never slot 0.
    checkOutput("wrap_alias_1", issue_alias, 1);
    setWb(0, 3'd2, 32'hB2, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h80, 5'd9, TYPE_ALU, 1'b0);
    checkOutput("commit_pulse_ends", cm_valid, 0);
    checkOutput("tail_after_wrap", issue_alias, 2);
    idle();
    checkOutput("commit2_alias", cm_alias, 2);
    checkOutput("commit2_data", cm_data, 32'hB2);
    idle();
    checkOutput("commit3_data", cm_data, 32'hDEAD);
    checkOutput("full_drops_at_5", full, 0);

    setWb(0, 3'd4, 32'hC4, 1'b0, 32'h0);
    setWb(1, 3'd5, 32'hC5, 1'b0, 32'h0);
    idle();
    checkOutput("head4_waits", cm_valid, 0);
    applyStimulus(1'b1, 32'h90, 5'd0, TYPE_ST, 1'b0);
    checkOutput("commit4_data", cm_data, 32'hC4);
    checkOutput("issue_retire_alias", issue_alias, 3);
    checkOutput("issue_retire_full", full, 0);

    setWb(0, 3'd3, 32'hBAD, 1'b0, 32'h0);
    setWb(1, 3'd6, 32'hC6, 1'b0, 32'h0);
    idle();
    checkOutput("commit5_data", cm_data, 32'hC5);
    qj = 3; qk = 6;
    #1;
    checkOutput("wb_to_empty_ignored", vj_ok, 0);
    checkOutput("vk6_ok", vk_ok, 1);
    checkOutput("vk6_data", vk, 32'hC6);

    setWb(0, 3'd7, 32'hC7, 1'b0, 32'h0);
    setWb(1, 3'd1, 32'hD1, 1'b0, 32'h0);
    idle();
    checkOutput("commit6_alias", cm_alias, 6);
    idle();
    checkOutput("commit7_alias", cm_alias, 7);
    idle();
    checkOutput("head_wrap_alias", cm_alias, 1);
    checkOutput("head_wrap_rd", cm_rd, 9);
    checkOutput("head_wrap_data", cm_data, 32'hD1);

    // Store retirement.
    setWb(0, 3'd2, 32'h0, 1'b0, 32'h0);
    idle();
    checkOutput("st_not_yet", st_commit, 0);
    idle();
    checkOutput("st_commit", st_commit, 1);
    checkOutput("st_alias", st_alias, 2);
    checkOutput("st_no_cm_valid", cm_valid, 0);

    // Mispredict: predicted not-taken, resolves taken to 0x200.
    checkOutput("br_alias", issue_alias, 3);
    applyStimulus(1'b1, 32'h100, 5'd0, TYPE_BR, 1'b0);
    applyStimulus(1'b1, 32'h104, 5'd6, TYPE_ALU, 1'b0);
    setWb(0, 3'd3, 32'h104, 1'b1, 32'h200);
    idle();
    setWb(0, 3'd4, 32'hF4, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h300, 5'd7, TYPE_ALU, 1'b0);
    checkOutput("rollback", rollback, 1);
    checkOutput("rollback_pc", rollback_pc, 32'h200);
    checkOutput("bp_update", bp_update, 1);
    checkOutput("bp_pc", bp_pc, 32'h100);
    checkOutput("bp_taken", bp_taken, 1);
    checkOutput("br_rd0_no_cm", cm_valid, 0);
    checkOutput("flush_tail_1", issue_alias, 1);
    checkOutput("flush_not_full", full, 0);
    qj = 4;
    #1;
    checkOutput("flushed_vj_ok", vj_ok, 0);
    idle();
    checkOutput("rollback_pulse_ends", rollback, 0);
    checkOutput("flush_issue_dropped", issue_alias, 1);

    // rdy low freezes state and masks pulses.
    applyStimulus(1'b1, 32'h400, 5'd5, TYPE_ALU, 1'b0);
    setWb(0, 3'd1, 32'hE1, 1'b0, 32'h0);
    idle();
    rdy = 1'b0;
    applyStimulus(1'b1, 32'h404, 5'd6, TYPE_ALU, 1'b0);
    checkOutput("frozen_cm_valid", cm_valid, 0);
    checkOutput("frozen_alias", issue_alias, 2);
    rdy = 1'b1;
    idle();
    checkOutput("resume_commit", cm_valid, 1);
    checkOutput("resume_data", cm_data, 32'hE1);

    // Reset in flight discards entries without a rollback.
    applyStimulus(1'b1, 32'h500, 5'd3, TYPE_ALU, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("midreset_alias", issue_alias, 1);
    checkOutput("midreset_no_rollback", rollback, 0);
    checkOutput("midreset_not_full", full, 0);
`else
    applyStimulus(1'b1, 32'h10, 5'd1, TYPE_ALU, 1'b0);
    applyStimulus(1'b1, 32'h14, 5'd2, TYPE_ALU, 1'b0);
    applyStimulus(1'b1, 32'h18, 5'd0, TYPE_ST, 1'b0);
    applyStimulus(1'b1, 32'h1C, 5'd4, TYPE_ALU, 1'b0);
    setWb(0, 3'd1, 32'h11, 1'b0, 32'h0);
    setWb(1, 3'd2, 32'h22, 1'b0, 32'h0);
    idle();
    checkOutput("dual_wait", cm_valid, 0);
    idle();
    checkOutput("dual_both_lanes", cm_valid, 2'b11);
    checkOutput("dual_lane0_data", cm_data[31:0], 32'h11);
    checkOutput("dual_lane1_data", cm_data[63:32], 32'h22);
    checkOutput("dual_lane1_alias", cm_alias[2*AW-1:AW], 2);
    setWb(0, 3'd3, 32'h0, 1'b0, 32'h0);
    setWb(1, 3'd4, 32'h44, 1'b0, 32'h0);
    idle();
    idle();
    checkOutput("dual_st_commit", st_commit, 1);
    checkOutput("dual_st_lanes_idle", cm_valid, 2'b00);
    idle();
    checkOutput("dual_single_after_st", cm_valid, 2'b01);
    checkOutput("dual_single_alias", cm_alias[AW-1:0], 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
